// File: rtl/sobel_pkg.sv
// Shared types and helpers for the Sobel gradient front-end.
// Optional build macro: SOBEL_ABS_EN (outputs |gx| and |gy| instead of signed values).
package sobel_pkg;

  localparam int PIX_W  = 8;
  localparam int GRAD_W = 11;

  typedef logic [PIX_W-1:0]  pixel_t;
  typedef logic [GRAD_W-1:0] grad_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } sobel_state_t;

  // Zero-extend a pixel into the gradient arithmetic width.
  function automatic grad_t zext(input pixel_t p);
    return {{(GRAD_W-PIX_W){1'b0}}, p};
  endfunction

  // Final output formatting: signed pass-through, or magnitude when SOBEL_ABS_EN.
  function automatic grad_t grad_fmt(input grad_t v);
`ifdef SOBEL_ABS_EN
    grad_t r;
    r = v[GRAD_W-1] ? (~v + grad_t'(1)) : v;
    return r;
`else
    return v;
`endif
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One-row delay line: dout presents the pixel shifted in IMG_WIDTH shifts ago,
// i.e. the same column of the previous row.
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH = 64
) (
  input  logic   clk,
  input  logic   n_rst,
  input  logic   shift_en,
  input  pixel_t din,
  output pixel_t dout
);

  pixel_t mem [IMG_WIDTH];

  // Shift the row delay line by one pixel on every accepted pixel.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < IMG_WIDTH; i++) begin
        mem[i] <= '0;
      end
    end else if (shift_en) begin
      mem[0] <= din;
      for (int i = 1; i < IMG_WIDTH; i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  assign dout = mem[IMG_WIDTH-1];

endmodule

// File: rtl/sobel_gradient_gen.sv
// Streaming 3x3 Sobel front-end: raster pixels in, one gx/gy pair per interior
// pixel out. Build macro SOBEL_ABS_EN switches gx/gy to magnitudes.
//
// Handshake semantics (both interfaces): a transfer happens on a rising clock
// edge where valid && ready are both high. The producer holds data stable while
// valid is high and ready is low. pixel_ready drops whenever the single output
// register is occupied and not being drained, and throughout DRAIN.
module sobel_gradient_gen
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64
) (
  input  logic         clk,
  input  logic         n_rst,
  input  pixel_t       pixel_in,
  input  logic         pixel_sof,
  input  logic         pixel_valid,
  output logic         pixel_ready,
  output grad_t        gx,
  output grad_t        gy,
  output logic         grad_valid,
  input  logic         grad_ready,
  output logic         frame_done,
  output sobel_state_t state_dbg
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  sobel_state_t  state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;

  pixel_t win [3][3];
  pixel_t lb1_out;
  pixel_t lb2_out;

  logic accept;
  logic shift_en;
  logic active_pix;
  logic last_pix;
  logic emit;

  grad_t right_sum, left_sum, bottom_sum, top_sum;
  grad_t gx_raw, gy_raw;

  assign pixel_ready = (state != DRAIN) && !(grad_valid && !grad_ready);
  assign accept      = pixel_valid && pixel_ready;
  // Pixels in IDLE without sof are dropped and must not disturb the window.
  assign shift_en    = accept && (pixel_sof || (state == ACTIVE));
  assign active_pix  = accept && (state == ACTIVE) && !pixel_sof;
  assign last_pix    = active_pix && (row == RW'(IMG_HEIGHT-1)) && (col == CW'(IMG_WIDTH-1));
  // Columns 0 and 1 only prime the window, so the previous row never leaks in.
  assign emit        = active_pix && (row >= RW'(2)) && (col >= CW'(2));
  assign state_dbg   = state;

  sobel_line_buffer #(.IMG_WIDTH(IMG_WIDTH)) u_lb_row1 (
    .clk      (clk),
    .n_rst    (n_rst),
    .shift_en (shift_en),
    .din      (pixel_in),
    .dout     (lb1_out)
  );

  sobel_line_buffer #(.IMG_WIDTH(IMG_WIDTH)) u_lb_row2 (
    .clk      (clk),
    .n_rst    (n_rst),
    .shift_en (shift_en),
    .din      (lb1_out),
    .dout     (lb2_out)
  );

  // Kernel over the window as it will look after this shift:
  // new col0 = win[*][1], new col1 = win[*][2], new col2 = {lb2_out, lb1_out, pixel_in}.
  always_comb begin
    right_sum  = zext(lb2_out) + (zext(lb1_out) << 1) + zext(pixel_in);
    left_sum   = zext(win[0][1]) + (zext(win[1][1]) << 1) + zext(win[2][1]);
    bottom_sum = zext(win[2][1]) + (zext(win[2][2]) << 1) + zext(pixel_in);
    top_sum    = zext(win[0][1]) + (zext(win[0][2]) << 1) + zext(lb2_out);
    gx_raw     = right_sum - left_sum;
    gy_raw     = bottom_sum - top_sum;
  end

  // Slide the 3x3 window one column left and insert the new column at the right.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win[r][c] <= '0;
        end
      end
    end else if (shift_en) begin
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= lb2_out;
      win[1][2] <= lb1_out;
      win[2][2] <= pixel_in;
    end
  end

  // Frame FSM with raster counters, output register and frame_done pulse.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      row        <= '0;
      col        <= '0;
      gx         <= '0;
      gy         <= '0;
      grad_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      if (emit) begin
        gx         <= grad_fmt(gx_raw);
        gy         <= grad_fmt(gy_raw);
        grad_valid <= 1'b1;
      end else if (grad_ready) begin
        grad_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (accept && pixel_sof) begin
            row   <= '0;
            col   <= CW'(1);
            state <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (accept) begin
            if (pixel_sof) begin
              row <= '0;
              col <= CW'(1);
            end else if (last_pix) begin
              row   <= '0;
              col   <= '0;
              state <= DRAIN;
            end else if (col == CW'(IMG_WIDTH-1)) begin
              col <= '0;
              row <= row + RW'(1);
            end else begin
              col <= col + CW'(1);
            end
          end
        end
        DRAIN: begin
          if (grad_valid && grad_ready) begin
            frame_done <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_gradient_gen.sv
// Directed bench for sobel_gradient_gen on a 4x4 raster with a scoreboard queue.
module tb_sobel_gradient_gen;
  import sobel_pkg::*;

  localparam int W    = 4;
  localparam int H    = 4;
  localparam int NPIX = W * H;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  pixel_t       pixel_in    = '0;
  logic         pixel_sof   = 1'b0;
  logic         pixel_valid = 1'b0;
  logic         pixel_ready;
  grad_t        gx, gy;
  logic         grad_valid;
  logic         grad_ready  = 1'b1;
  logic         frame_done;
  sobel_state_t state_dbg;

  sobel_gradient_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .pixel_in    (pixel_in),
    .pixel_sof   (pixel_sof),
    .pixel_valid (pixel_valid),
    .pixel_ready (pixel_ready),
    .gx          (gx),
    .gy          (gy),
    .grad_valid  (grad_valid),
    .grad_ready  (grad_ready),
    .frame_done  (frame_done),
    .state_dbg   (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  logic [2*GRAD_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int out_cnt  = 0;
  int done_cnt = 0;
  pixel_t frame_px [NPIX];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic grad_t fmt(input int v);
    grad_t g;
    g = grad_t'(v);
`ifdef SOBEL_ABS_EN
    if (v < 0) g = grad_t'(-v);
`endif
    return g;
  endfunction

  task automatic push_exp(input int egx, input int egy);
    exp_q.push_back({fmt(egx), fmt(egy)});
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [2*GRAD_W-1:0] e;
    forever begin
      @(negedge clk);
      if (n_rst) begin
        if (frame_done) done_cnt++;
        if (grad_valid && grad_ready) begin
          out_cnt++;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output: got gx=0x%0h gy=0x%0h expected no output", gx, gy);
          end else begin
            e = exp_q.pop_front();
            check("grad_pair", {21'd0, gx, gy}, {10'd0, e});
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_pixel(input pixel_t p, input logic sof);
    bit acc;
    int guard;
    pixel_in    = p;
    pixel_sof   = sof;
    pixel_valid = 1'b1;
    acc   = 1'b0;
    guard = 0;
    while (!acc && guard < 200) begin
      @(negedge clk);
      acc = pixel_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got no pixel_ready expected acceptance within 200 cycles");
    end
    pixel_valid = 1'b0;
    pixel_sof   = 1'b0;
  endtask

  task automatic send_frame(input int n);
    for (int i = 0; i < n; i++) send_pixel(frame_px[i], i == 0);
  endtask

  task automatic wait_frame_done(input int exp_done);
    int guard;
    guard = 0;
    while (done_cnt < exp_done && guard < 200) begin
      @(posedge clk);
      guard++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("frame_done_count", done_cnt, exp_done);
    check("queue_empty", exp_q.size(), 0);
  endtask

  task automatic fill_cols(input pixel_t c0, input pixel_t c1, input pixel_t c2, input pixel_t c3);
    for (int r = 0; r < H; r++) begin
      frame_px[r*W+0] = c0;
      frame_px[r*W+1] = c1;
      frame_px[r*W+2] = c2;
      frame_px[r*W+3] = c3;
    end
  endtask

  task automatic fill_rows10();
    for (int i = 0; i < NPIX; i++) frame_px[i] = pixel_t'(10 * (i / W));
  endtask

  task automatic fill_order();
    for (int i = 0; i < NPIX; i++) frame_px[i] = pixel_t'(10 * (i / W) * (i / W) + (i % W) * (i % W));
  endtask

  task automatic push_order();
    push_exp(16, 160);
    push_exp(32, 160);
    push_exp(16, 320);
    push_exp(32, 320);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    n_rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_grad_valid", grad_valid, 0);
    check("rst_gx", gx, 0);
    check("rst_gy", gy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_state", state_dbg, IDLE);
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_rst", pixel_ready, 1);

    // Flat frame
    for (int i = 0; i < NPIX; i++) frame_px[i] = 8'd100;
    for (int i = 0; i < 4; i++) push_exp(0, 0);
    send_frame(NPIX);
    wait_frame_done(1);
    check("flat_out_count", out_cnt, 4);

    // Rising horizontal edge
    fill_cols(8'd0, 8'd0, 8'd255, 8'd255);
    for (int i = 0; i < 4; i++) push_exp(1020, 0);
    send_frame(NPIX);
    wait_frame_done(2);

    // Falling horizontal edge
    fill_cols(8'd255, 8'd255, 8'd0, 8'd0);
    for (int i = 0; i < 4; i++) push_exp(-1020, 0);
    send_frame(NPIX);
    wait_frame_done(3);

    // Vertical ramp with latency check around pixel (2,2)
    fill_rows10();
    for (int i = 0; i < 4; i++) push_exp(0, 80);
    for (int i = 0; i < NPIX; i++) begin
      send_pixel(frame_px[i], i == 0);
      if (i == 9)  check("latency_before", grad_valid, 0);
      if (i == 10) check("latency_after", grad_valid, 1);
    end
    wait_frame_done(4);

    // Distinct pairs with a downstream stall
    fill_order();
    push_order();
    grad_ready = 1'b0;
    fork
      send_frame(NPIX);
      begin : stall
        int guard;
        guard = 0;
        do begin
          @(negedge clk);
          guard++;
        end while (!grad_valid && guard < 200);
        check("stall_seen_valid", grad_valid, 1);
        repeat (5) begin
          @(negedge clk);
          check("stall_pixel_ready", pixel_ready, 0);
          check("stall_hold", {10'd0, gx, gy}, {10'd0, fmt(16), fmt(160)});
        end
        @(posedge clk);
        #1;
        grad_ready = 1'b1;
      end
    join
    wait_frame_done(5);
    check("stall_out_count", out_cnt, 20);

    // Pixels without sof in IDLE are dropped
    for (int i = 0; i < 5; i++) send_pixel(8'd50, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    check("idle_no_output", out_cnt, 20);
    check("idle_state", state_dbg, IDLE);

    // Abandon a frame in row 2, then restart
    for (int i = 0; i < 10; i++) send_pixel(8'd200, i == 0);
    check("mid_frame_state", state_dbg, ACTIVE);
    fill_rows10();
    for (int i = 0; i < 4; i++) push_exp(0, 80);
    send_frame(NPIX);
    wait_frame_done(6);
    check("restart_out_count", out_cnt, 24);

    // Asynchronous reset while an output is pending
    fill_cols(8'd0, 8'd0, 8'd255, 8'd255);
    grad_ready = 1'b0;
    for (int i = 0; i < 11; i++) send_pixel(frame_px[i], i == 0);
    check("pre_reset_valid", grad_valid, 1);
    #2;
    n_rst = 1'b0;
    #1;
    check("async_rst_valid", grad_valid, 0);
    check("async_rst_gx", gx, 0);
    check("async_rst_gy", gy, 0);
    check("async_rst_done", frame_done, 0);
    check("async_rst_state", state_dbg, IDLE);
    repeat (2) @(posedge clk);
    #1;
    n_rst      = 1'b1;
    grad_ready = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_rst2", pixel_ready, 1);
    fill_order();
    push_order();
    send_frame(NPIX);
    wait_frame_done(7);
    check("total_outputs", out_cnt, 28);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
